uart_tx_console: RTL

// Console character transmitter for the pipelined core's memory-mapped output port.
// The core stores ASCII bytes to the console register (same use as the LEDR char port).

---
 rtl/uart_tx_console.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_console.sv
// Console character transmitter: buffers bytes stored by the core in a small
// FIFO and shifts them out as 8N1 UART frames on o_tx (idle high, LSB first).
module uart_tx_console #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_en,
  input  logic [7:0]                    i_wr_data,
  input  logic                          i_ovf_clr,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FSM and serializer state
  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  // FIFO state
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            ovf_q, ovf_d;

  logic            push;
  logic            drop;
  logic            pop;
  logic            bit_end;
  logic [7:0]      head;

  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (baud_q == '0);

  // Frame sequencer: pops the FIFO head on frame entry, times each bit with the baud counter
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shreg_d = head;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = BAUD_RELOAD;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
          baud_d    = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          baud_d  = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (!empty_q) begin
            // Back-to-back frame: the next start bit follows the stop bit directly
            pop     = 1'b1;
            shreg_d = head;
            state_d = ST_START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            baud_d  = BAUD_RELOAD;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            baud_d  = '0;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        baud_d  = '0;
      end
    endcase
  end

  // FIFO bookkeeping: a write is judged against the registered full flag, so a
  // write in a full cycle is dropped even when the sequencer pops in that cycle
  always_comb begin
    push     = i_wr_en && !full_q;
    drop     = i_wr_en && full_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    ovf_d    = ovf_q;
    if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Control state register with synchronous reset; aborts any frame in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
    end
  end

  // Data storage: shift register and FIFO array carry no reset; validity is tracked by control
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
    if (push && !i_reset) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_fifo_cnt = count_q;
  assign o_ovf      = ovf_q;

endmodule
